// File: rtl/shift_seq8.sv
// shift_seq8: sequences LOAD plus LSL/LSR/ASR steps of at most 3 positions over an 8-bit data register.
// Optional rotate-right support for cmd=11 is enabled by defining SHIFT_SEQ8_ROR_EN.
module shift_seq8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       cmd,
    input  logic [2:0]       amount,
    input  logic [WIDTH-1:0] d_in,
    output logic [2:0]       op,
    output logic [1:0]       shamt,
    output logic [WIDTH-1:0] d_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t           state;
    logic [2:0]       rem;
    logic [2:0]       amt_eff;
    logic [1:0]       cmd_q;
    logic [1:0]       step;
    logic [WIDTH-1:0] din_q;
    logic [WIDTH-1:0] asr_v;
    logic [WIDTH-1:0] ror_v;
    logic [WIDTH-1:0] shifted;
`ifdef SHIFT_SEQ8_ROR_EN
    assign amt_eff = amount;
    assign ror_v   = (d_out >> step) | (d_out << (WIDTH - int'(step)));
`else
    // Without rotate support, cmd=11 degenerates to a plain load.
    assign amt_eff = (cmd == 2'b11) ? 3'd0 : amount;
    assign ror_v   = d_out;
`endif
    assign step    = (rem > 3'd3) ? 2'd3 : rem[1:0];
    assign asr_v   = $signed(d_out) >>> step;
    assign shifted = (cmd_q == 2'b00) ? d_out << step :
                     (cmd_q == 2'b01) ? d_out >> step :
                     (cmd_q == 2'b10) ? asr_v : ror_v;
    assign busy    = state != IDLE;
    assign done    = state == DONE;
    assign op      = (state == LOAD)  ? 3'd1 :
                     (state == SHIFT) ? {1'b0, cmd_q} + 3'd2 : 3'd0;
    assign shamt   = (state == SHIFT) ? step : 2'd0;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            d_out <= '0;
            rem   <= '0;
            cmd_q <= '0;
            din_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cmd_q <= cmd;
                    din_q <= d_in;
                    rem   <= amt_eff;
                    state <= LOAD;
                end
                LOAD: begin
                    d_out <= din_q;
                    state <= (rem == 3'd0) ? DONE : SHIFT;
                end
                SHIFT: begin
                    d_out <= shifted;
                    rem   <= rem - {1'b0, step};
                    state <= (rem == {1'b0, step}) ? DONE : SHIFT;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shift_seq8.sv
// tb_shift_seq8: scoreboard bench for shift_seq8; ROR cases follow SHIFT_SEQ8_ROR_EN.
module tb_shift_seq8;
    logic       clk = 0, reset = 1, start = 0;
    logic [1:0] cmd = 0;
    logic [2:0] amount = 0;
    logic [7:0] d_in = 0;
    logic [2:0] op;
    logic [1:0] shamt;
    logic [7:0] d_out;
    logic       busy, done;
    shift_seq8 #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd(cmd), .amount(amount), .d_in(d_in),
        .op(op), .shamt(shamt), .d_out(d_out), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    typedef struct { logic [7:0] d; int c; } res_t;
    logic [4:0] op_q[$];
    res_t       res_q[$];
    int         busy_q[$];
    int         checks = 0, errors = 0, run = 0;
    res_t       r;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s got %0h want none (queue empty)", name, act);
    endtask
    always @(negedge clk) begin
        if (reset) run = 0;
        else begin
            if (op != 3'd0) begin
                if (op_q.size() == 0) unexpected("op_shamt", {op, shamt});
                else chk("op_shamt", {op, shamt}, op_q.pop_front());
            end
            if (busy) run++;
            else if (run > 0) begin
                if (busy_q.size() == 0) unexpected("busy_len", run);
                else chk("busy_len", run, busy_q.pop_front());
                run = 0;
            end
            if (done) begin
                if (res_q.size() == 0) unexpected("done_pulse", d_out);
                else begin
                    r = res_q.pop_front();
                    chk("d_out", d_out, r.d);
                    chk("done_cycle", cyc, r.c);
                end
            end
        end
    end
    function automatic logic [2:0] op_of(input logic [1:0] c);
        return {1'b0, c} + 3'd2;
    endfunction
    task automatic issue(input logic [1:0] c, input logic [2:0] a, input logic [7:0] d, input logic [7:0] exp);
        int k, rem, s;
        @(negedge clk);
        cmd = c; amount = a; d_in = d; start = 1;
`ifndef SHIFT_SEQ8_ROR_EN
        if (c == 2'b11) a = 0;
`endif
        k = (int'(a) + 2) / 3;
        op_q.push_back({3'd1, 2'd0});
        rem = a;
        while (rem > 0) begin
            s = rem > 3 ? 3 : rem;
            op_q.push_back({op_of(c), 2'(s)});
            rem -= s;
        end
        res_q.push_back('{exp, cyc + 2 + k});
        busy_q.push_back(2 + k);
        @(negedge clk);
        start = 0; cmd = 2'($urandom); amount = 3'($urandom); d_in = 8'($urandom);
    endtask
    task automatic wait_idle();
        int i = 0;
        while ((res_q.size() != 0 || busy) && i < 30) begin
            @(negedge clk); #1;
            i++;
        end
        if (i >= 30) begin
            checks++; errors++;
            $display("FAIL timeout got pending=%0d want 0", res_q.size());
        end
    endtask
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        #1 reset = 0;
        repeat (3) begin
            @(negedge clk); #1;
            chk("idle_d_out", d_out, 8'h00);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_op", op, 3'd0);
        end
        issue(2'b00, 3'd7, 8'h81, 8'h80); wait_idle();
        issue(2'b10, 3'd4, 8'h90, 8'hF9); wait_idle();
        issue(2'b01, 3'd5, 8'h81, 8'h04); wait_idle();
        issue(2'b01, 3'd0, 8'h5A, 8'h5A); wait_idle();
        issue(2'b00, 3'd3, 8'h0F, 8'h78); wait_idle();
        issue(2'b01, 3'd6, 8'hF0, 8'h03); wait_idle();
        issue(2'b10, 3'd2, 8'h40, 8'h10); wait_idle();
        issue(2'b10, 3'd4, 8'h90, 8'hF9);
        @(negedge clk);
        start = 1; cmd = 2'b00; amount = 3'd1; d_in = 8'hFF;
        @(negedge clk);
        start = 0;
        wait_idle();
`ifdef SHIFT_SEQ8_ROR_EN
        issue(2'b11, 3'd1, 8'h81, 8'hC0); wait_idle();
        issue(2'b11, 3'd4, 8'h12, 8'h21); wait_idle();
        issue(2'b11, 3'd7, 8'h01, 8'h02); wait_idle();
`else
        issue(2'b11, 3'd4, 8'h12, 8'h12); wait_idle();
        issue(2'b11, 3'd7, 8'h81, 8'h81); wait_idle();
`endif
        @(negedge clk);
        cmd = 2'b00; amount = 3'd7; d_in = 8'h81; start = 1;
        op_q.push_back({3'd1, 2'd0});
        op_q.push_back({3'd2, 2'd3});
        @(negedge clk);
        start = 0;
        @(negedge clk); #1 reset = 1;
        @(negedge clk); #1 reset = 0;
        chk("abort_busy", busy, 0);
        chk("abort_d_out", d_out, 8'h00);
        chk("abort_done", done, 0);
        chk("abort_op", op, 3'd0);
        repeat (5) @(negedge clk);
        #1;
        chk("op_q_empty", op_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        chk("busy_q_empty", busy_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog got running want finished");
        $fatal(1, "watchdog");
    end
endmodule
